// File: rtl/wb_reg_file_pkg.sv
// Shared constants and helpers for the write-back register file slice.
// Widths here set the parameter defaults of every module and the interface.
package wb_reg_file_pkg;

  localparam int unsigned WORD_BUS = 32;
  localparam int unsigned REG_BUS  = 5;
  localparam int unsigned REG_NUM  = 32;

  localparam logic [WORD_BUS-1:0] ZERO_WORD = '0;
  localparam logic [REG_BUS-1:0]  ZERO_REG  = '0;

  typedef logic [WORD_BUS-1:0] word_t;
  typedef logic [REG_BUS-1:0]  reg_t;

  // Index 0 is the idle encoding from the upstream pipeline register.
  function automatic logic wb_is_write(input reg_t dest);
    return dest != ZERO_REG;
  endfunction

endpackage

// File: rtl/wb_reg_file_if.sv
// Bus bundle between the pipeline (write-back producer, decode reader, debug)
// and the register file.
interface wb_reg_file_if
  import wb_reg_file_pkg::*;
#(
  parameter int unsigned DATA_W = WORD_BUS,
  parameter int unsigned ADDR_W = REG_BUS
);

  logic [ADDR_W-1:0] wb_regDest;
  logic [DATA_W-1:0] wb_value;

  logic              id_readEn1;
  logic [ADDR_W-1:0] id_readAddr1;
  logic [DATA_W-1:0] id_readData1;

  logic              id_readEn2;
  logic [ADDR_W-1:0] id_readAddr2;
  logic [DATA_W-1:0] id_readData2;

  logic [ADDR_W-1:0] dbg_readAddr;
  logic [DATA_W-1:0] dbg_readData;

  modport master (
    output wb_regDest, wb_value,
    output id_readEn1, id_readAddr1,
    input  id_readData1,
    output id_readEn2, id_readAddr2,
    input  id_readData2,
    output dbg_readAddr,
    input  dbg_readData
  );

  modport slave (
    input  wb_regDest, wb_value,
    input  id_readEn1, id_readAddr1,
    output id_readData1,
    input  id_readEn2, id_readAddr2,
    output id_readData2,
    input  dbg_readAddr,
    output dbg_readData
  );

endinterface

// File: rtl/wb_reg_file_read_port.sv
// One decode read port: reset / enable / register-0 / bypass / storage
// priority mux, fully combinational.
module wb_reg_read_port
  import wb_reg_file_pkg::*;
#(
  parameter int unsigned DATA_W = WORD_BUS,
  parameter int unsigned ADDR_W = REG_BUS
) (
  input  logic              i_rst,
  input  logic              i_en,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [ADDR_W-1:0] i_wb_dest,
  input  logic [DATA_W-1:0] i_wb_value,
  input  logic [DATA_W-1:0] i_store_data,
  output logic [DATA_W-1:0] o_data
);

  logic w_blocked;
  logic w_bypass;

  assign w_blocked = i_rst || !i_en || (i_addr == '0);
  // A nonzero i_addr matching i_wb_dest implies a write is in flight.
  assign w_bypass  = (i_addr == i_wb_dest);

  always_comb begin
    o_data = '0;
    if (w_blocked) begin
      o_data = '0;
    end else if (w_bypass) begin
      o_data = i_wb_value;
    end else begin
      o_data = i_store_data;
    end
  end

endmodule

// File: rtl/wb_reg_file.sv
// Architectural register file fed by the write-back stage, with two bypassed
// decode read ports and one storage-only debug port.
module wb_reg_file
  import wb_reg_file_pkg::*;
#(
  parameter int unsigned DATA_W   = WORD_BUS,
  parameter int unsigned ADDR_W   = REG_BUS,
  parameter int unsigned NUM_REGS = REG_NUM
) (
  input  logic          clk,
  input  logic          rst,
  wb_reg_file_if.slave  bus
);

  logic [DATA_W-1:0] r_regs [NUM_REGS];

  logic [DATA_W-1:0] w_store1;
  logic [DATA_W-1:0] w_store2;
  logic [DATA_W-1:0] w_dbg_data;
  logic              w_wr_en;

  assign w_wr_en = (bus.wb_regDest != '0);

  // Storage: reset dominates any same-edge write; entry 0 is never written.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_regs[bus.wb_regDest] <= bus.wb_value;
    end
  end

  assign w_store1 = r_regs[bus.id_readAddr1];
  assign w_store2 = r_regs[bus.id_readAddr2];

  wb_reg_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_port1 (
    .i_rst        (rst),
    .i_en         (bus.id_readEn1),
    .i_addr       (bus.id_readAddr1),
    .i_wb_dest    (bus.wb_regDest),
    .i_wb_value   (bus.wb_value),
    .i_store_data (w_store1),
    .o_data       (bus.id_readData1)
  );

  wb_reg_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_port2 (
    .i_rst        (rst),
    .i_en         (bus.id_readEn2),
    .i_addr       (bus.id_readAddr2),
    .i_wb_dest    (bus.wb_regDest),
    .i_wb_value   (bus.wb_value),
    .i_store_data (w_store2),
    .o_data       (bus.id_readData2)
  );

  // Debug port reads committed storage only, never the bypass.
  always_comb begin
    w_dbg_data = '0;
    if (!rst && (bus.dbg_readAddr != '0)) begin
      w_dbg_data = r_regs[bus.dbg_readAddr];
    end
  end

  assign bus.dbg_readData = w_dbg_data;

endmodule

// File: tb/tb_wb_reg_file.sv
// Self-checking bench for wb_reg_file: directed scenarios plus random traffic
// checked against an array-based reference model.
module tb_wb_reg_file;
  import wb_reg_file_pkg::*;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  wb_reg_file_if bus ();

  wb_reg_file dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  logic [31:0] mem [32];
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_id(input logic en, input logic [4:0] a);
    if (rst || !en || a == 5'd0) return 32'd0;
    if (a == bus.wb_regDest) return bus.wb_value;
    return mem[a];
  endfunction

  function automatic logic [31:0] exp_dbg(input logic [4:0] a);
    if (rst || a == 5'd0) return 32'd0;
    return mem[a];
  endfunction

  task automatic drive(input logic r, input logic [4:0] d, input logic [31:0] v,
                       input logic e1, input logic [4:0] a1,
                       input logic e2, input logic [4:0] a2, input logic [4:0] da);
    rst              = r;
    bus.wb_regDest   = d;
    bus.wb_value     = v;
    bus.id_readEn1   = e1;
    bus.id_readAddr1 = a1;
    bus.id_readEn2   = e2;
    bus.id_readAddr2 = a2;
    bus.dbg_readAddr = da;
    #2;
  endtask

  task automatic check_all(input string tag);
    check({tag, "_rd1"}, bus.id_readData1, exp_id(bus.id_readEn1, bus.id_readAddr1));
    check({tag, "_rd2"}, bus.id_readData2, exp_id(bus.id_readEn2, bus.id_readAddr2));
    check({tag, "_dbg"}, bus.dbg_readData, exp_dbg(bus.dbg_readAddr));
  endtask

  // Advance one edge and apply the architectural effect of that edge to the model.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) mem[i] = 32'd0;
    end else if (bus.wb_regDest != 5'd0) begin
      mem[bus.wb_regDest] = bus.wb_value;
    end
    #1;
  endtask

  initial begin
    logic       r, e1, e2;
    logic [4:0] d, a1, a2, da;

    // Power-on reset; outputs forced to 0 during rst regardless of inputs.
    drive(1'b1, 5'd6, 32'h1111_1111, 1'b1, 5'd6, 1'b1, 5'd3, 5'd6);
    check("rst_rd1", bus.id_readData1, 32'd0);
    check("rst_rd2", bus.id_readData2, 32'd0);
    tick();
    tick();

    // Reset clear of a preloaded entry.
    drive(1'b0, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 1'b0, 5'd0, 5'd5);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 1'b1, 5'd5, 5'd5);
    check("pre_dbg5", bus.dbg_readData, 32'hDEAD_BEEF);
    drive(1'b1, 5'd0, 32'd0, 1'b1, 5'd5, 1'b1, 5'd5, 5'd5);
    check_all("inrst");
    check("inrst_rd1c", bus.id_readData1, 32'd0);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 1'b1, 5'd5, 5'd5);
    check("post_rst_dbg5", bus.dbg_readData, 32'd0);
    check_all("post_rst");

    // Basic write then read.
    drive(1'b0, 5'd3, 32'h1234_5678, 1'b0, 5'd0, 1'b0, 5'd0, 5'd3);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 1'b0, 5'd3, 5'd3);
    check("wr3_rd1", bus.id_readData1, 32'h1234_5678);
    check("wr3_dbg", bus.dbg_readData, 32'h1234_5678);
    tick();
    check_all("wr3_again");

    // Bypass on both ports; debug sees old value until after the edge.
    drive(1'b0, 5'd7, 32'h0000_0001, 1'b0, 5'd0, 1'b0, 5'd0, 5'd7);
    tick();
    drive(1'b0, 5'd7, 32'hA5A5_A5A5, 1'b1, 5'd7, 1'b1, 5'd7, 5'd7);
    check("byp_rd1", bus.id_readData1, 32'hA5A5_A5A5);
    check("byp_rd2", bus.id_readData2, 32'hA5A5_A5A5);
    check("byp_dbg_old", bus.dbg_readData, 32'h0000_0001);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 1'b1, 5'd7, 5'd7);
    check("byp_dbg_new", bus.dbg_readData, 32'hA5A5_A5A5);

    // Idle encoding never writes; register 0 reads 0 everywhere.
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 5'd0, 32'hFFFF_FFFF, 1'b1, 5'd0, 1'b1, 5'd0, 5'd0);
      check("r0_rd1", bus.id_readData1, 32'd0);
      check("r0_rd2", bus.id_readData2, 32'd0);
      tick();
    end
    for (int k = 0; k < 32; k++) begin
      drive(1'b0, 5'd0, 32'hFFFF_FFFF, 1'b1, 5'd0, 1'b1, 5'd0, 5'(k));
      check($sformatf("sweep%0d", k), bus.dbg_readData, exp_dbg(5'(k)));
    end

    // Enable gating on port 2.
    drive(1'b0, 5'd9, 32'h0000_0055, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd9, 1'b0, 5'd9, 5'd9);
    check("en2_off", bus.id_readData2, 32'd0);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd9, 1'b1, 5'd9, 5'd9);
    check("en2_on", bus.id_readData2, 32'h0000_0055);

    // Reset wins over a same-edge write; the next write lands normally.
    drive(1'b1, 5'd4, 32'h0000_0077, 1'b1, 5'd4, 1'b1, 5'd4, 5'd4);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 1'b1, 5'd4, 5'd4);
    check("coll_rd1", bus.id_readData1, 32'd0);
    check("coll_dbg", bus.dbg_readData, 32'd0);
    drive(1'b0, 5'd4, 32'h0000_0088, 1'b0, 5'd0, 1'b0, 5'd0, 5'd4);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 1'b1, 5'd4, 5'd4);
    check("coll_wr_rd1", bus.id_readData1, 32'h0000_0088);
    check("coll_wr_dbg", bus.dbg_readData, 32'h0000_0088);

    // Random traffic biased toward bypass hits and back-to-back writes.
    for (int n = 0; n < 400; n++) begin
      r  = ($urandom_range(0, 24) == 0);
      d  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      e1 = ($urandom_range(0, 3) != 0);
      e2 = ($urandom_range(0, 3) != 0);
      a1 = ($urandom_range(0, 2) == 0) ? d : 5'($urandom_range(0, 31));
      a2 = ($urandom_range(0, 2) == 0) ? a1 : 5'($urandom_range(0, 31));
      da = ($urandom_range(0, 2) == 0) ? d : 5'($urandom_range(0, 31));
      drive(r, d, $urandom, e1, a1, e2, a2, da);
      check_all($sformatf("rnd%0d", n));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_reg_file.md
Name: wb_reg_file

Overview:
Architectural register file at the consuming end of the write-back stage. It accepts the registered write-back pair (destination, value) every cycle and commits it to storage. It serves two combinational read ports to the decode stage, plus one debug read port. A write-back bypass returns a value to decode in the same cycle it is written, so no decode/write-back hazard window exists.

Parameters:
DATA_W, 32, width of each register and of all data ports (matches WORD_BUS)
ADDR_W, 5, register index width (matches REG_BUS)
NUM_REGS, 32, number of architectural registers; must equal 2**ADDR_W

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
wb_regDest  input  ADDR_W  write-back destination index; 0 means no write
wb_value  input  DATA_W  write-back data
id_readEn1  input  1  read port 1 enable
id_readAddr1  input  ADDR_W  read port 1 index
id_readData1  output  DATA_W  read port 1 data (combinational)
id_readEn2  input  1  read port 2 enable
id_readAddr2  input  ADDR_W  read port 2 index
id_readData2  output  DATA_W  read port 2 data (combinational)
dbg_readAddr  input  ADDR_W  debug/bench read index
dbg_readData  output  DATA_W  debug read data, storage only, no bypass

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high. On a rising edge with rst=1, all NUM_REGS entries clear to 0.
- Outputs while rst=1: id_readData1, id_readData2 and dbg_readData all drive 0, regardless of address or enable.
- Write:
  - On a rising edge with rst=0 and wb_regDest != 0, entry[wb_regDest] <= wb_value.
  - wb_regDest = 0 performs no write. This is the idle encoding produced by the upstream pipeline register after reset or a bubble.
- Register 0: never written, always reads 0 on every port.
- Read port n (n = 1, 2), evaluated in priority order:
  1. rst=1 -> 0
  2. id_readEnn=0 -> 0
  3. id_readAddrn=0 -> 0
  4. id_readAddrn == wb_regDest (nonzero) -> wb_value (bypass)
  5. otherwise -> entry[id_readAddrn]
- Latency:
  - Write data is visible on id ports in the same cycle it is presented (bypass), and from storage on every cycle after the commit edge.
  - The debug port sees a write only from the cycle after the commit edge.
- Simultaneous events:
  - Both read ports may address the same register. Both return identical data, including the bypass case.
  - Reset asserted in the same edge as a nonzero wb_regDest: reset wins, and the entry is 0 afterwards.
  - Back-to-back writes to the same index: last write wins. The bypass always reflects the current-cycle wb_value.
- Reset mid-operation: storage is cleared on the edge. There is no pending state, so the first cycle after rst deasserts behaves as power-on.
- No X propagation: all outputs are defined for every input combination once rst has been applied.

Decomposition:
- Shared define include holds the constants: REG_BUS, WORD_BUS, ZERO_WORD, ZERO_REG (index 0), REG_NUM.
- Parameters default from these constants.
- One natural sub-module, wb_reg_read_port:
  - Implements the enable / zero / bypass / storage priority mux for one port.
  - Instantiated twice, for read ports 1 and 2.
- Storage array and write logic stay in the top module.

Test Plan:
- Reset clear: preload r5=0xDEADBEEF, assert rst one cycle -> dbg_readData for r5 = 0, and all id reads = 0 while rst=1.
- Basic write/read: wb_regDest=3, wb_value=0x12345678 for one edge, then wb_regDest=0 -> id_readAddr1=3, En1=1 reads 0x12345678 on the following cycles; dbg port matches.
- Bypass: r7 holds 0x1; present wb_regDest=7, wb_value=0xA5A5A5A5 with id_readAddr1=id_readAddr2=7 in the same cycle -> both ports return 0xA5A5A5A5 that cycle; dbg_readData returns 0x1 until after the edge.
- Register 0 and idle encoding: wb_regDest=0, wb_value=0xFFFFFFFF over several edges -> no entry changes (sweep the dbg port over all 32), and id reads of address 0 = 0.
- Enable gating: r9=0x55, id_readEn2=0, id_readAddr2=9 -> id_readData2=0; raise En2 -> 0x55.
- Reset vs write collision: rst=1 with wb_regDest=4, wb_value=0x77 on the same edge -> r4 reads 0 after rst deasserts; write 0x88 the next cycle -> r4 reads 0x88.
